// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : circular instruction queue decoupling fetch from decode.
// Revision    : 1.0
// ============================================================================
module fetch_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    validF,
  input  logic [DATA_WIDTH-1:0]   instrF,
  input  logic [DATA_WIDTH-1:0]   PCF,
  input  logic [DATA_WIDTH-1:0]   PCPlus4F,
  output logic                    readyF,
  input  logic                    stallD,
  input  logic                    flush,
  output logic                    validD,
  output logic [DATA_WIDTH-1:0]   instrD,
  output logic [DATA_WIDTH-1:0]   PCD,
  output logic [DATA_WIDTH-1:0]   PCPlus4D,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0]       c_depth = c_cw'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] c_nop   = DATA_WIDTH'(32'h0000_0013);

  logic [DATA_WIDTH-1:0] r_instr  [DEPTH];
  logic [DATA_WIDTH-1:0] r_pc     [DEPTH];
  logic [DATA_WIDTH-1:0] r_pcp4   [DEPTH];
  logic [c_aw-1:0]       r_rptr;
  logic [c_aw-1:0]       r_wptr;
  logic [c_cw-1:0]       r_count;

  logic w_ready;
  logic w_valid;
  logic w_push;
  logic w_pop;

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign w_ready = (r_count < c_depth) && !flush;
  assign w_valid = (r_count != '0);
  assign w_push  = validF && w_ready;
  assign w_pop   = w_valid && !stallD && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
    end else if (flush) begin
      r_count <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_aw'(1);
      if (w_pop)  r_rptr <= r_rptr + c_aw'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wptr] <= instrF;
      r_pc[r_wptr]    <= PCF;
      r_pcp4[r_wptr]  <= PCPlus4F;
    end
  end

  assign readyF   = w_ready;
  assign validD   = w_valid;
  assign count    = r_count;
  assign instrD   = w_valid ? r_instr[r_rptr] : c_nop;
  assign PCD      = w_valid ? r_pc[r_rptr]    : '0;
  assign PCPlus4D = w_valid ? r_pcp4[r_rptr]  : '0;

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of instruction and PC fields.
REQ-002 SHALL have parameter DEPTH, default 4, number of entries; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port validF  input  1  fetch presents a valid instruction this cycle.
REQ-006 SHALL have port instrF  input  DATA_WIDTH  fetched instruction.
REQ-007 SHALL have port PCF  input  DATA_WIDTH  PC of the fetched instruction.
REQ-008 SHALL have port PCPlus4F  input  DATA_WIDTH  PC+4 of the fetched instruction.
REQ-009 SHALL have port readyF  output  1  queue accepts a push this cycle; drives fetch enable.
REQ-010 SHALL have port stallD  input  1  decode cannot consume this cycle.
REQ-011 SHALL have port flush  input  1  redirect from execute (PCSrcE); discard all entries.
REQ-012 SHALL have port validD  output  1  instrD/PCD/PCPlus4D hold a real instruction.
REQ-013 SHALL have port instrD  output  DATA_WIDTH  head-entry instruction, or NOP when empty.
REQ-014 SHALL have port PCD  output  DATA_WIDTH  head-entry PC, or 0 when empty.
REQ-015 SHALL have port PCPlus4D  output  DATA_WIDTH  head-entry PC+4, or 0 when empty.
REQ-016 SHALL have port count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-017 SHALL store each entry as {instr, PC, PCPlus4} in a DEPTH-entry circular buffer with read pointer, write pointer and occupancy counter.
REQ-018 SHALL assert readyF = (count < DEPTH) and not flush; no push-when-full even if a pop occurs the same cycle.
REQ-019 SHALL perform a push when validF and readyF; entry written at write pointer, pointer +1 modulo DEPTH.
REQ-020 SHALL perform a pop when validD and not stallD and not flush; read pointer +1 modulo DEPTH.
REQ-021 SHALL update count: +1 push only, -1 pop only, unchanged when both or neither.
REQ-022 SHALL drive validD = (count != 0); instrD/PCD/PCPlus4D combinationally from head entry when validD.
REQ-023 SHALL drive instrD = 32'h00000013 (addi x0,x0,0), PCD = 0, PCPlus4D = 0 when empty.
REQ-024 SHALL give push-to-visible latency of exactly one cycle; no same-cycle bypass from instrF to instrD.
REQ-025 SHALL, on flush, set count, read pointer and write pointer to 0 at next edge, ignoring any simultaneous push or pop.
REQ-026 SHALL keep head entry outputs stable while stallD is high and no flush occurs.
REQ-027 SHALL preserve FIFO order across pointer wrap-around.
REQ-028 SHALL never underflow: a pop is impossible when count = 0 since validD = 0.

Reset
REQ-029 SHALL, while reset is low, asynchronously clear count and both pointers to 0; validD = 0, readyF = 1 (flush low), instrD = NOP, PCD = 0, PCPlus4D = 0.
REQ-030 SHALL discard all in-flight entries if reset asserts mid-operation; storage contents need not be cleared.
REQ-031 SHALL resume normal operation on the first rising edge after reset deasserts.

Verification
REQ-032 Reset then idle -> validD=0, instrD=0x00000013, readyF=1, count=0.
REQ-033 Push PC 0x00,0x04,0x08,0x0C with stallD=1 -> count=4, readyF=0, fifth push ignored, instrD = instr at PC 0x00.
REQ-034 From full, stallD=0 for 4 cycles, validF=0 -> PCD sequence 0x00,0x04,0x08,0x0C, then validD=0, count=0.
REQ-035 Continuous push and pop for 10 cycles (PC 0x00..0x24) -> count constant at 1, PCD trails PCF by one cycle, order preserved across wrap.
REQ-036 Queue holding 3 entries, flush=1 with validF=1 -> next cycle count=0, validD=0, pushed entry dropped; following push of PC 0x40 appears as PCD=0x40 one cycle later.
REQ-037 Reset low asserted mid-stream with count=2 -> validD=0 immediately without clock edge; after release, count=0, readyF=1.
